// File: rtl/kv_defines_pkg.sv
// Shared types and constants for the key-vault block assembly path.
package kv_defines_pkg;

  localparam int unsigned KV_DWORD_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b01,
    FULL  = 2'b10
  } kv_asm_state_e;

  // Offset width for a buffer of the given dword count (at least 1 bit).
  function automatic int unsigned kv_offset_w(input int unsigned num_dwords);
    return (num_dwords > 1) ? $clog2(num_dwords) : 1;
  endfunction

endpackage

// File: rtl/kv_dword_buf.sv
// Dword register array with indexed write, synchronous clear and a flattened
// big-endian view (dword 0 in the most significant 32 bits).
module kv_dword_buf
  import kv_defines_pkg::*;
#(
  parameter  int unsigned NUM_DWORDS = 16,
  localparam int unsigned OFFSET_W   = kv_offset_w(NUM_DWORDS)
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic                             clr,
  input  logic                             wr,
  input  logic [OFFSET_W-1:0]              wr_offset,
  input  logic [KV_DWORD_W-1:0]            wr_data,
  output logic [NUM_DWORDS*KV_DWORD_W-1:0] flat
);

  // Ascending element range puts element 0 in the top bits of the packed vector.
  logic [0:NUM_DWORDS-1][KV_DWORD_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (wr) begin
      mem[wr_offset] <= wr_data;
    end
  end

  assign flat = mem;

endmodule

// File: rtl/kv_block_assembler.sv
// Assembles key-vault read / pad dwords into a block and hands it to the
// crypto core over valid/ready, backpressuring the read FSM until consumed.
module kv_block_assembler
  import kv_defines_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 512,
  localparam int unsigned NUM_DWORDS = DATA_WIDTH / KV_DWORD_W,
  localparam int unsigned OFFSET_W   = kv_offset_w(NUM_DWORDS)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  zeroize,
  input  logic                  write_en,
  input  logic [OFFSET_W-1:0]   write_offset,
  input  logic                  write_pad,
  input  logic [KV_DWORD_W-1:0] pad_data,
  input  logic [KV_DWORD_W-1:0] kv_rd_data,
  input  logic                  write_last,
  output logic                  asm_ready,
  output logic [DATA_WIDTH-1:0] block,
  output logic                  block_valid,
  input  logic                  core_ready,
  output logic [OFFSET_W:0]     dword_cnt,
  output logic                  wr_err,
  input  logic                  err_clr
);

  localparam int unsigned CNT_W = OFFSET_W + 1;

  kv_asm_state_e         state;
  kv_asm_state_e         state_next;
  logic                  wr_ok;
  logic                  consume;
  logic [KV_DWORD_W-1:0] wdata;

  assign wdata = write_pad ? pad_data : kv_rd_data;

  // Next state plus write-accept / consume decode; zeroize overrides everything.
  always_comb begin
    state_next = state;
    wr_ok      = 1'b0;
    consume    = 1'b0;
    case (state)
      EMPTY: begin
        if (write_en) begin
          wr_ok      = 1'b1;
          state_next = write_last ? FULL : FILL;
        end
      end
      FILL: begin
        if (write_en) begin
          wr_ok = 1'b1;
          if (write_last) state_next = FULL;
        end
      end
      FULL: begin
        if (core_ready) begin
          consume    = 1'b1;
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (zeroize) begin
      state_next = EMPTY;
      wr_ok      = 1'b0;
      consume    = 1'b0;
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= EMPTY;
      asm_ready   <= 1'b1;
      block_valid <= 1'b0;
    end else begin
      state       <= state_next;
      asm_ready   <= (state_next == EMPTY);
      block_valid <= (state_next == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dword_cnt <= '0;
    end else if (zeroize || consume) begin
      dword_cnt <= '0;
    end else if (wr_ok && (dword_cnt != CNT_W'(NUM_DWORDS))) begin
      dword_cnt <= dword_cnt + CNT_W'(1);
    end
  end

  // A new overrun beats a simultaneous clear so no error is lost.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_err <= 1'b0;
    end else if (zeroize) begin
      wr_err <= 1'b0;
    end else if (write_en && (state == FULL)) begin
      wr_err <= 1'b1;
    end else if (err_clr) begin
      wr_err <= 1'b0;
    end
  end

  kv_dword_buf #(
    .NUM_DWORDS(NUM_DWORDS)
  ) u_buf (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (zeroize | consume),
    .wr       (wr_ok),
    .wr_offset(write_offset),
    .wr_data  (wdata),
    .flat     (block)
  );

endmodule

// File: tb/tb_kv_block_assembler.sv
// Directed bench for kv_block_assembler at DATA_WIDTH=512.
module tb_kv_block_assembler;
  import kv_defines_pkg::*;

  localparam int unsigned DW  = 512;
  localparam int unsigned NUM = 16;
  localparam int unsigned OW  = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          zeroize;
  logic          write_en;
  logic [OW-1:0] write_offset;
  logic          write_pad;
  logic [31:0]   pad_data;
  logic [31:0]   kv_rd_data;
  logic          write_last;
  logic          asm_ready;
  logic [DW-1:0] block;
  logic          block_valid;
  logic          core_ready;
  logic [OW:0]   dword_cnt;
  logic          wr_err;
  logic          err_clr;

  int checks   = 0;
  int failures = 0;

  kv_block_assembler #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .zeroize     (zeroize),
    .write_en    (write_en),
    .write_offset(write_offset),
    .write_pad   (write_pad),
    .pad_data    (pad_data),
    .kv_rd_data  (kv_rd_data),
    .write_last  (write_last),
    .asm_ready   (asm_ready),
    .block       (block),
    .block_valid (block_valid),
    .core_ready  (core_ready),
    .dword_cnt   (dword_cnt),
    .wr_err      (wr_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          we;
    int          off;
    bit          pad;
    logic [31:0] pd;
    logic [31:0] kv;
    bit          last;
    bit          cr;
    bit          eclr;
    bit          zer;
    bit          e_rdy;
    bit          e_val;
    int          e_cnt;
    bit          e_err;
    int          ci;
    logic [31:0] cdw;
  } vec_t;

  vec_t        vt[13];
  logic [DW-1:0] exp_blk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dw_of(input logic [DW-1:0] b, input int i);
    return b[DW-1-32*i -: 32];
  endfunction

  task automatic idle();
    zeroize      = 1'b0;
    write_en     = 1'b0;
    write_offset = '0;
    write_pad    = 1'b0;
    pad_data     = 32'h0;
    kv_rd_data   = 32'h0;
    write_last   = 1'b0;
    core_ready   = 1'b0;
    err_clr      = 1'b0;
  endtask

  // One write; the unselected source carries junk to exercise the mux.
  task automatic wr(input int off, input bit pad, input logic [31:0] d, input bit last);
    write_en     = 1'b1;
    write_offset = OW'(off);
    write_pad    = pad;
    pad_data     = pad ? d : 32'hFFFF_FFFF;
    kv_rd_data   = pad ? 32'hBAD0_0000 : d;
    write_last   = last;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic consume();
    core_ready = 1'b1;
    @(posedge clk); #1;
    core_ready = 1'b0;
  endtask

  task automatic set_dw(input int i, input logic [31:0] d);
    exp_blk[DW-1-32*i -: 32] = d;
  endtask

  initial begin
    //       we off pad pd            kv            last cr eclr zer rdy val cnt err ci cdw
    vt[0]  = '{1, 0, 0, 32'h0,        32'h0000_00A1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 32'h0000_00A1};
    vt[1]  = '{1, 1, 1, 32'h8000_0000, 32'hDEAD_0001, 0, 0, 0, 0,  0, 0, 2, 0, 1, 32'h8000_0000};
    vt[2]  = '{1, 1, 0, 32'h0,        32'h0000_00B2, 0, 0, 0, 0,  0, 0, 3, 0, 1, 32'h0000_00B2};
    vt[3]  = '{0, 2, 0, 32'h0,        32'h0000_0EEE, 1, 0, 0, 0,  0, 0, 3, 0, 1, 32'h0000_00B2};
    vt[4]  = '{1, 3, 0, 32'h0,        32'h0000_00C3, 1, 0, 0, 0,  0, 1, 4, 0, 3, 32'h0000_00C3};
    vt[5]  = '{1, 3, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0,  0, 1, 4, 1, 3, 32'h0000_00C3};
    vt[6]  = '{0, 0, 0, 32'h0,        32'h0,         0, 0, 1, 0,  0, 1, 4, 0, 3, 32'h0000_00C3};
    vt[7]  = '{1, 2, 0, 32'h0,        32'h1111_1111, 0, 1, 0, 0,  1, 0, 0, 1, 2, 32'h0};
    vt[8]  = '{0, 0, 0, 32'h0,        32'h0,         0, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0};
    vt[9]  = '{1, 0, 0, 32'h0,        32'h0000_0055, 1, 0, 0, 0,  0, 1, 1, 0, 0, 32'h0000_0055};
    vt[10] = '{1, 0, 0, 32'h0,        32'h0000_0066, 0, 0, 1, 0,  0, 1, 1, 1, 0, 32'h0000_0055};
    vt[11] = '{1, 1, 0, 32'h0,        32'h0000_0099, 0, 0, 0, 1,  1, 0, 0, 0, 0, 32'h0};
    vt[12] = '{1, 0, 0, 32'h0,        32'h0000_0077, 1, 0, 0, 1,  1, 0, 0, 0, 0, 32'h0};

    idle();
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_block", block, '0);
    chk("rst_ready", DW'(asm_ready), DW'(1));
    chk("rst_valid", DW'(block_valid), DW'(0));
    chk("rst_cnt", DW'(dword_cnt), DW'(0));
    chk("rst_err", DW'(wr_err), DW'(0));
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Table-driven control vectors, one clock each.
    for (int v = 0; v < 13; v++) begin
      write_en     = vt[v].we;
      write_offset = OW'(vt[v].off);
      write_pad    = vt[v].pad;
      pad_data     = vt[v].pd;
      kv_rd_data   = vt[v].kv;
      write_last   = vt[v].last;
      core_ready   = vt[v].cr;
      err_clr      = vt[v].eclr;
      zeroize      = vt[v].zer;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", v), DW'(asm_ready), DW'(vt[v].e_rdy));
      chk($sformatf("v%0d_valid", v), DW'(block_valid), DW'(vt[v].e_val));
      chk($sformatf("v%0d_cnt", v), DW'(dword_cnt), DW'(vt[v].e_cnt));
      chk($sformatf("v%0d_err", v), DW'(wr_err), DW'(vt[v].e_err));
      chk($sformatf("v%0d_dw%0d", v, vt[v].ci), DW'(dw_of(block, vt[v].ci)), DW'(vt[v].cdw));
    end
    idle();
    @(posedge clk); #1;

    // Full 16-dword block then consume.
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      wr(i, 1'b0, 32'h1000_0000 + 32'(i), i == 15);
      set_dw(i, 32'h1000_0000 + 32'(i));
      if (i == 14) chk("full_valid_early", DW'(block_valid), DW'(0));
    end
    chk("full_valid", DW'(block_valid), DW'(1));
    chk("full_ready", DW'(asm_ready), DW'(0));
    chk("full_dw0", DW'(block[511:480]), DW'(32'h1000_0000));
    chk("full_dw15", DW'(block[31:0]), DW'(32'h1000_000F));
    chk("full_cnt", DW'(dword_cnt), DW'(16));
    chk("full_block", block, exp_blk);
    @(posedge clk); #1;
    chk("full_hold", block, exp_blk);
    consume();
    chk("cons_ready", DW'(asm_ready), DW'(1));
    chk("cons_valid", DW'(block_valid), DW'(0));
    chk("cons_block", block, '0);
    chk("cons_cnt", DW'(dword_cnt), DW'(0));

    // Pad mix.
    exp_blk = '0;
    wr(0, 1'b0, 32'hA0A0_A0A0, 1'b0); set_dw(0, 32'hA0A0_A0A0);
    wr(1, 1'b0, 32'hB1B1_B1B1, 1'b0); set_dw(1, 32'hB1B1_B1B1);
    wr(2, 1'b1, 32'h8000_0000, 1'b0); set_dw(2, 32'h8000_0000);
    for (int i = 3; i < 15; i++) wr(i, 1'b1, 32'h0, 1'b0);
    wr(15, 1'b1, 32'h0000_0040, 1'b1); set_dw(15, 32'h0000_0040);
    chk("pad_dw2", DW'(dw_of(block, 2)), DW'(32'h8000_0000));
    chk("pad_dw15", DW'(dw_of(block, 15)), DW'(32'h0000_0040));
    chk("pad_block", block, exp_blk);
    consume();

    // Short block: unwritten dwords read zero.
    exp_blk = '0;
    for (int i = 0; i < 3; i++) begin
      wr(i, 1'b0, 32'h0000_00C0 + 32'(i), i == 2);
      set_dw(i, 32'h0000_00C0 + 32'(i));
    end
    chk("short_valid", DW'(block_valid), DW'(1));
    chk("short_cnt", DW'(dword_cnt), DW'(3));
    chk("short_block", block, exp_blk);
    consume();

    // Zeroize mid-fill, then a block with a trailing rewrite (count saturates).
    for (int i = 0; i < 5; i++) wr(i, 1'b0, 32'h5000_0000 + 32'(i), 1'b0);
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    chk("zer_block", block, '0);
    chk("zer_cnt", DW'(dword_cnt), DW'(0));
    chk("zer_ready", DW'(asm_ready), DW'(1));
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      wr(i, 1'b0, 32'h0300_0000 + 32'(i * 3), 1'b0);
      set_dw(i, 32'h0300_0000 + 32'(i * 3));
    end
    chk("sat_valid_early", DW'(block_valid), DW'(0));
    chk("sat_cnt_16", DW'(dword_cnt), DW'(16));
    wr(0, 1'b0, 32'hABCD_0000, 1'b1); set_dw(0, 32'hABCD_0000);
    chk("sat_cnt", DW'(dword_cnt), DW'(16));
    chk("sat_valid", DW'(block_valid), DW'(1));
    chk("sat_block", block, exp_blk);
    consume();

    // Async reset while FULL.
    wr(5, 1'b0, 32'h5A5A_5A5A, 1'b1);
    chk("ar_valid_pre", DW'(block_valid), DW'(1));
    #2;
    rst_b = 1'b0;
    #1;
    chk("ar_valid", DW'(block_valid), DW'(0));
    chk("ar_ready", DW'(asm_ready), DW'(1));
    chk("ar_block", block, '0);
    chk("ar_cnt", DW'(dword_cnt), DW'(0));
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kv_block_assembler.md
Name: kv_block_assembler

Overview:
- Downstream consumer of the key-vault read FSM write stream.
- Captures 32-bit dwords, either key-vault read data or FSM-generated pad words, into a DATA_WIDTH block register.
- Presents the completed block to the crypto core (SHA/HMAC/ECC input) with a valid/ready handshake.
- Backpressures the FSM, so a new key-vault read only starts once the previous block has been consumed.

Parameters:
- DATA_WIDTH, 512, block width in bits; multiple of 32, at least 64.
- OFFSET_W, $clog2(DATA_WIDTH/32), localparam, dword offset width.
- NUM_DWORDS, DATA_WIDTH/32, localparam.

Ports:
- clk, input, 1, clock.
- rst_b, input, 1, asynchronous active-low reset.
- zeroize, input, 1, synchronous clear of all state and data.
- write_en, input, 1, dword write strobe from FSM.
- write_offset, input, OFFSET_W, dword index to write.
- write_pad, input, 1, 1 = take pad_data, 0 = take kv_rd_data.
- pad_data, input, 32, FSM-generated pad/length dword.
- kv_rd_data, input, 32, key-vault read data for the current offset; valid in the same cycle as write_en.
- write_last, input, 1, final dword of block.
- asm_ready, output, 1, high only in EMPTY; FSM start is gated by it.
- block, output, DATA_WIDTH, assembled block; dword 0 in bits [DATA_WIDTH-1 -: 32] (big-endian dword order).
- block_valid, output, 1, block complete and stable.
- core_ready, input, 1, crypto core accepts the block.
- dword_cnt, output, OFFSET_W+1, number of dwords written in the current block.
- wr_err, output, 1, sticky: write attempted while FULL.
- err_clr, input, 1, clears wr_err.

Behaviour:
- Reset (rst_b low, async) values:
  - block = 0, dword_cnt = 0, block_valid = 0, wr_err = 0.
  - asm_ready = 1, state = EMPTY.
- Zeroize (sync, highest priority after reset): next cycle, same values as reset. Any in-flight block is discarded, and a write in the same cycle is ignored.
- Write data selection: wdata = write_pad ? pad_data : kv_rd_data.
- A write (write_en=1, state != FULL) stores wdata into dword[write_offset] at the next clock edge and increments dword_cnt, saturating at NUM_DWORDS.
- Rewrites to the same offset overwrite the dword and still count.
- States (2-bit enum):
  - EMPTY: asm_ready=1, block_valid=0.
    - write_en & !write_last -> FILL.
    - write_en & write_last -> FULL (single-dword block).
  - FILL: asm_ready=0, block_valid=0.
    - write_en & write_last -> FULL.
    - Otherwise stays in FILL.
  - FULL: block_valid=1, asm_ready=0.
    - block and dword_cnt are held stable.
    - block_valid & core_ready -> EMPTY; block and dword_cnt clear to 0 on the same edge.
- Latency:
  - The last write is captured at edge N, and block_valid rises in cycle N+1.
  - Handshake completes at edge M, and asm_ready is 1 in cycle M+1.
- Unwritten dwords read 0: the buffer is cleared on consume, so short blocks are zero-filled.
- A write in FULL is dropped (data unchanged) and sets wr_err at the next edge.
- A write in the same cycle as the handshake is also dropped and flagged; the FSM must not do this, since asm_ready is low.
- wr_err is cleared by err_clr or zeroize. If err_clr and a new error occur in the same cycle, the set wins.
- write_last without write_en is ignored.
- An offset beyond NUM_DWORDS-1 cannot occur by width; no check is made.
- No combinational path from any input to block_valid or asm_ready; both are decoded from registered state only.

Decomposition:
- Shared in kv_defines_pkg:
  - kv_asm_state_e (EMPTY=2'b00, FILL=2'b01, FULL=2'b10).
  - KV_DWORD_W = 32.
- Optional sub-module kv_dword_buf: NUM_DWORDS x 32 register array with indexed write, synchronous clear and flattened big-endian output.
- FSM, counter and error logic stay in the top module.

Test Plan:
- Full 16-dword block, DATA_WIDTH=512:
  - Stimulus: write offsets 0..15 with kv_rd_data = 0x1000_0000+i, last on offset 15, core_ready=0.
  - Response: block_valid=1 the next cycle, block[511:480]=0x1000_0000, block[31:0]=0x1000_000F, dword_cnt=16. Then core_ready=1 -> asm_ready=1 and block=0 one cycle later.
- Pad mix:
  - Stimulus: 2 data dwords, then pad dword 0x8000_0000 at offset 2, zeros, and length 0x40 at offset 15 with last.
  - Response: dword2=0x8000_0000, dword15=0x0000_0040, dwords 3..14 = 0.
- Short block:
  - Stimulus: 3 writes (offsets 0..2), last on 2.
  - Response: block_valid=1, dword_cnt=3, dwords 3..15 = 0.
- Overrun:
  - Stimulus: write_en with data 0xDEAD_BEEF while FULL.
  - Response: block unchanged, wr_err=1 the next cycle; err_clr -> wr_err=0.
- Zeroize mid-fill:
  - Stimulus: zeroize after 5 of 16 writes.
  - Response: next cycle block=0, dword_cnt=0, asm_ready=1; a new block then assembles correctly.
- Async reset while FULL:
  - Stimulus: assert rst_b=0 mid-cycle while FULL.
  - Response: block_valid drops immediately, asm_ready=1.
